// File: rtl/pipe_div_ctrl_if.sv
// Bus between the pipeline controller and its surroundings: pipeline
// requests, EX divide operands, the shared divider handshake and the stall bus.
interface pipe_div_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
);
  // pipeline side
  logic                  stallreq_id;
  logic                  flush;
  logic                  ex_div_req;
  logic                  ex_div_signed;
  logic [DATA_W-1:0]     ex_opa;
  logic [DATA_W-1:0]     ex_opb;
  logic [STALL_W-1:0]    stall;
  logic                  div_res_vld;
  logic [2*DATA_W-1:0]   div_res;
  logic                  div_err;
  // divider side
  logic                  div_go;
  logic                  div_signed;
  logic [DATA_W-1:0]     div_a;
  logic [DATA_W-1:0]     div_b;
  logic                  div_done;
  logic [DATA_W-1:0]     div_quot;
  logic [DATA_W-1:0]     div_rem;
  // controller FSM state, for observation only
  logic [2:0]            dbg_state;

  modport master (
    input  stallreq_id, flush, ex_div_req, ex_div_signed, ex_opa, ex_opb,
           div_done, div_quot, div_rem,
    output stall, div_res_vld, div_res, div_err,
           div_go, div_signed, div_a, div_b, dbg_state
  );

  modport slave (
    output stallreq_id, flush, ex_div_req, ex_div_signed, ex_opa, ex_opb,
           div_done, div_quot, div_rem,
    input  stall, div_res_vld, div_res, div_err,
           div_go, div_signed, div_a, div_b, dbg_state
  );
endinterface

// File: rtl/pipe_div_ctrl.sv
// Central pipeline controller: merges the ID load-use stall with EX divide
// sequencing, drives the 6-bit stall bus and owns the divider handshake.
//
// Divider handshake: div_go is a one-cycle start pulse issued with div_a,
// div_b and div_signed already stable; the divider answers with a one-cycle
// div_done pulse carrying div_quot/div_rem. There is no back-pressure:
// div_done is consumed in the cycle it appears, and only WAIT/DRAIN listen.
module pipe_div_ctrl #(
  parameter int STALL_W = 6,
  parameter int DATA_W  = 32,
  parameter int MAX_CYC = 40
) (
  input  logic            clk,
  input  logic            rst,
  pipe_div_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [STALL_W-1:0] STALL_EX = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_ID = STALL_W'(6'b000111);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             start_ok;
  logic             timeout;
  logic             err_set;
  logic             res_latch;

  assign start_ok  = bus.ex_div_req && !bus.flush;
  // >= rather than == so a WAIT that flushes on its last cycle still times out in DRAIN
  assign timeout   = (cnt >= CNT_LAST);
  assign res_latch = (state == S_WAIT) && bus.div_done && !bus.flush;
  assign err_set   = !bus.div_done && timeout &&
                     (((state == S_WAIT) && !bus.flush) || (state == S_DRAIN));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_START;
      S_START: state_nx = bus.flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.div_done)   state_nx = bus.flush ? S_IDLE : S_DONE;
        else if (bus.flush) state_nx = S_DRAIN;
        else if (timeout)   state_nx = S_IDLE;
      end
      S_DONE:  state_nx = S_IDLE;
      S_DRAIN: if (bus.div_done || timeout) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, watchdog counter, result latch and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.div_a      <= '0;
      bus.div_b      <= '0;
      bus.div_signed <= 1'b0;
      bus.div_res    <= '0;
      bus.div_err    <= 1'b0;
      cnt            <= '0;
    end else begin
      if ((state == S_IDLE) && start_ok) begin
        bus.div_a      <= bus.ex_opa;
        bus.div_b      <= bus.ex_opb;
        bus.div_signed <= bus.ex_div_signed;
      end
      if (state == S_START)
        cnt <= '0;
      else if (((state == S_WAIT) || (state == S_DRAIN)) && (cnt != CNT_SAT))
        cnt <= cnt + 1'b1;
      if (res_latch) bus.div_res <= {bus.div_rem, bus.div_quot};
      if (err_set)   bus.div_err <= 1'b1;
    end
  end

  // Stall bus: flush wins, then EX divide, then a new divide blocked by DRAIN, then ID
  always_comb begin
    bus.stall = '0;
    if (!rst || bus.flush)
      bus.stall = '0;
    else if (((state == S_IDLE) && bus.ex_div_req) || (state == S_START) || (state == S_WAIT))
      bus.stall = STALL_EX;
    else if ((state == S_DRAIN) && bus.ex_div_req)
      bus.stall = STALL_EX;
    else if (bus.stallreq_id)
      bus.stall = STALL_ID;
  end

  assign bus.div_go      = (state == S_START);
  assign bus.div_res_vld = (state == S_DONE);
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_pipe_div_ctrl.sv
// Bench for pipe_div_ctrl: a behavioural divider answers div_go after a
// programmable latency; expected results are queued when a divide is issued.
module tb_pipe_div_ctrl;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        sreq;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  // divider model and stimulus-side overrides of the divider inputs
  int          div_lat;
  logic        rsp_done, stim_done;
  logic [31:0] rsp_quot, rsp_rem, stim_quot, stim_rem;
  logic [31:0] rsp_a, rsp_b;
  logic        rsp_s;
  int          rsp_n;

  pipe_div_ctrl_if bus ();

  assign bus.div_done = rsp_done | stim_done;
  assign bus.div_quot = rsp_quot ^ stim_quot;
  assign bus.div_rem  = rsp_rem ^ stim_rem;

  pipe_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / safety net
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench stopped");
  end

  // behavioural divider: answers div_go after div_lat cycles (0 = never)
  initial begin
    rsp_done = 1'b0;
    rsp_quot = '0;
    rsp_rem  = '0;
    forever begin
      @(negedge clk);
      if (bus.div_go && div_lat > 0) begin
        rsp_a = bus.div_a;
        rsp_b = bus.div_b;
        rsp_s = bus.div_signed;
        rsp_n = div_lat;
        repeat (rsp_n) @(posedge clk);
        #1;
        rsp_done = 1'b1;
        if (rsp_s) begin
          rsp_quot = $signed(rsp_a) / $signed(rsp_b);
          rsp_rem  = $signed(rsp_a) % $signed(rsp_b);
        end else begin
          rsp_quot = rsp_a / rsp_b;
          rsp_rem  = rsp_a % rsp_b;
        end
        @(posedge clk);
        #1;
        rsp_done = 1'b0;
        rsp_quot = '0;
        rsp_rem  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // run cycles until div_res_vld, scoring the result against the queue
  task automatic wait_vld(input logic [5:0] done_stall, output int go_cnt, output int st_cnt);
    bit got;
    got    = 1'b0;
    go_cnt = 0;
    st_cnt = 0;
    for (int c = 0; c < 120 && !got; c++) begin
      @(negedge clk);
      if (bus.div_go) go_cnt++;
      if (bus.stall == STALL_EX) st_cnt++;
      if (bus.div_res_vld) begin
        got = 1'b1;
        chk("done_stall", 64'(bus.stall), 64'(done_stall));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", bus.div_res);
        end else begin
          chk("div_res", bus.div_res, exp_q.pop_front());
        end
      end
      tick();
    end
    bus.ex_div_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL vld_timeout: got no div_res_vld expected one within 120 cycles");
    end
    @(negedge clk);
    chk("vld_one_cycle", 64'(bus.div_res_vld), 64'd0);
    chk("after_done_stall", 64'(bus.stall), 64'(done_stall));
    tick();
  endtask

  vec_t vecs[6];
  int   go_cnt, st_cnt, cnt_a, cnt_b;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          33, 1'b0, 32'd14,         32'd2};
    vecs[1] = '{1'b0, 32'd1000,       32'd10,         3,  1'b1, 32'd100,        32'd0};
    vecs[2] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          1,  1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         5,  1'b1, 32'h0FFF_FFFF,  32'd15};
    vecs[4] = '{1'b1, 32'd20,         32'hFFFF_FFFD,  40, 1'b0, 32'hFFFF_FFFA,  32'd2};
    vecs[5] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  2,  1'b0, 32'd14,         32'hFFFF_FFFE};

    checks = 0;
    errors = 0;
    last_exp = '0;
    div_lat = 0;
    stim_done = 1'b0;
    stim_quot = '0;
    stim_rem  = '0;
    bus.stallreq_id = 1'b0;
    bus.flush = 1'b0;
    bus.ex_div_req = 1'b0;
    bus.ex_div_signed = 1'b0;
    bus.ex_opa = '0;
    bus.ex_opb = '0;
    rst = 1'b0;

    // reset held: inputs toggle, every output stays 0
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.stallreq_id   = 1'($urandom_range(0, 1));
      bus.flush         = 1'($urandom_range(0, 1));
      bus.ex_div_req    = 1'($urandom_range(0, 1));
      bus.ex_div_signed = 1'($urandom_range(0, 1));
      bus.ex_opa        = $urandom;
      bus.ex_opb        = $urandom;
      stim_done         = 1'($urandom_range(0, 1));
      stim_quot         = $urandom;
      stim_rem          = $urandom;
      @(negedge clk);
      chk("rst_ctrl", 64'({bus.div_go, bus.div_signed, bus.div_res_vld, bus.div_err, bus.stall, bus.dbg_state}), 64'd0);
      chk("rst_ops", {bus.div_a, bus.div_b}, 64'd0);
      chk("rst_res", bus.div_res, 64'd0);
    end
    tick();
    bus.stallreq_id = 1'b0;
    bus.flush = 1'b0;
    bus.ex_div_req = 1'b0;
    stim_done = 1'b0;
    stim_quot = '0;
    stim_rem  = '0;
    rst = 1'b1;

    // released: stall follows stallreq_id only, flush masks it
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.stallreq_id = 1'($urandom_range(0, 1));
      bus.flush = (i == 7);
      @(negedge clk);
      chk("id_stall", 64'(bus.stall), (bus.stallreq_id && !bus.flush) ? 64'(STALL_ID) : 64'd0);
      chk("id_state", 64'(bus.dbg_state), 64'd0);
    end
    tick();
    bus.stallreq_id = 1'b0;
    bus.flush = 1'b0;

    // table of divides: latency, stall length, result, ID stall after DONE
    for (int i = 0; i < 6; i++) begin
      bus.stallreq_id   = vecs[i].sreq;
      bus.ex_div_req    = 1'b1;
      bus.ex_div_signed = vecs[i].sgn;
      bus.ex_opa        = vecs[i].a;
      bus.ex_opb        = vecs[i].b;
      div_lat           = vecs[i].lat;
      exp_q.push_back({vecs[i].r, vecs[i].q});
      last_exp = {vecs[i].r, vecs[i].q};
      wait_vld(vecs[i].sreq ? STALL_ID : 6'b0, go_cnt, st_cnt);
      chk("go_pulses", 64'(go_cnt), 64'd1);
      chk("ex_stall_cycles", 64'(st_cnt), 64'(vecs[i].lat + 2));
      bus.stallreq_id = 1'b0;
    end

    // flush in WAIT, drain, new divide queued behind the drain
    bus.ex_div_req = 1'b1;
    bus.ex_div_signed = 1'b0;
    bus.ex_opa = 32'd50;
    bus.ex_opb = 32'd5;
    div_lat = 33;
    @(negedge clk);
    chk("t4_req_stall", 64'(bus.stall), 64'(STALL_EX));
    tick();
    @(negedge clk);
    chk("t4_go", 64'(bus.div_go), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      chk("t4_wait_stall", 64'(bus.stall), 64'(STALL_EX));
    end
    tick();
    bus.flush = 1'b1;
    bus.ex_div_req = 1'b0;
    @(negedge clk);
    chk("t4_flush_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("t4_drain_state", 64'(bus.dbg_state), 64'd4);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 7; k <= 9; k++) begin
      tick();
      @(negedge clk);
      if (bus.div_res_vld || bus.stall != 6'b0) cnt_a++;
    end
    chk("t4_drain_quiet", 64'(cnt_a), 64'd0);
    tick();
    bus.ex_div_req = 1'b1;
    bus.ex_opa = 32'd9;
    bus.ex_opb = 32'd4;
    div_lat = 4;
    exp_q.push_back({32'd1, 32'd2});
    cnt_a = 0;
    for (int k = 10; k <= 33; k++) begin
      @(negedge clk);
      if (bus.stall == STALL_EX) cnt_a++;
      if (bus.div_res_vld) cnt_b++;
      tick();
    end
    @(negedge clk);
    chk("t4_drain_req_stall", 64'(cnt_a), 64'd24);
    chk("t4_no_vld", 64'(cnt_b), 64'd0);
    chk("t4_idle_req_stall", 64'(bus.stall), 64'(STALL_EX));
    chk("t4_res_kept", bus.div_res, last_exp);
    tick();
    wait_vld(6'b0, go_cnt, st_cnt);
    chk("t4_new_go", 64'(go_cnt), 64'd1);
    chk("t4_new_stall", 64'(st_cnt), 64'd5);

    // watchdog: divider never answers
    bus.ex_div_req = 1'b1;
    bus.ex_opa = 32'd1;
    bus.ex_opb = 32'd1;
    div_lat = 0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t5_go", 64'(bus.div_go), 64'd1);
    cnt_a = 0;
    for (int k = 1; k <= 39; k++) begin
      tick();
      @(negedge clk);
      if (bus.stall == STALL_EX && !bus.div_err) cnt_a++;
    end
    chk("t5_wait_stall", 64'(cnt_a), 64'd39);
    tick();
    bus.ex_div_req = 1'b0;
    @(negedge clk);
    chk("t5_err_before", 64'(bus.div_err), 64'd0);
    chk("t5_last_stall", 64'(bus.stall), 64'(STALL_EX));
    tick();
    @(negedge clk);
    chk("t5_err_set", 64'(bus.div_err), 64'd1);
    chk("t5_stall", 64'(bus.stall), 64'd0);
    chk("t5_state", 64'(bus.dbg_state), 64'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_err_sticky", 64'(bus.div_err), 64'd1);
    chk("t5_no_vld", 64'(bus.div_res_vld), 64'd0);
    tick();

    // reset mid-WAIT, late div_done ignored
    bus.ex_div_req = 1'b1;
    bus.ex_opa = 32'd77;
    bus.ex_opb = 32'd7;
    div_lat = 20;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6_go", 64'(bus.div_go), 64'd1);
    repeat (5) tick();
    rst = 1'b0;
    #2;
    chk("t6_async_state", 64'(bus.dbg_state), 64'd0);
    chk("t6_async_outs", 64'({bus.stall, bus.div_err, bus.div_go, bus.div_res_vld}), 64'd0);
    bus.ex_div_req = 1'b0;
    tick();
    rst = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.div_res_vld || bus.stall != 6'b0 || bus.dbg_state != 3'd0) cnt_a++;
      tick();
    end
    chk("t6_late_done_ignored", 64'(cnt_a), 64'd0);
    chk("t6_res_cleared", bus.div_res, 64'd0);
    chk("t6_err_cleared", 64'(bus.div_err), 64'd0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
